// File: rtl/seq_alu_mc.sv
// Sequential ALU: single-cycle push/add/sub and an ALU_W-cycle radix-2 shift-add multiplier,
// with optional saturation and an overflow flag qualified by o_valid.
module seq_alu_mc #(
    parameter int ALU_W = 8,
    parameter int IM_W  = 4,
    parameter int SAT   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ALU_W-1:0] i_data_a,
    input  logic [ALU_W-1:0] i_data_b,
    input  logic [1:0]       i_op,
    input  logic [IM_W-1:0]  i_const,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [ALU_W-1:0] o_data,
    output logic             o_valid,
    output logic             o_ovf
);

    typedef enum logic [1:0] {
        OP_PUSH = 2'b00,
        OP_ADD  = 2'b01,
        OP_MULT = 2'b10,
        OP_SUB  = 2'b11
    } op_e;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_e;

    localparam int              CNT_W = $clog2(ALU_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ALU_W - 1);

    state_e state_q, state_d;
    op_e    op;
    logic   accept;

    logic [2*ALU_W-1:0] acc, mcand, prod_next;
    logic [ALU_W-1:0]   mplier;
    logic [CNT_W-1:0]   cnt;
    logic               mul_last;
    logic               mul_ovf;
    logic [ALU_W-1:0]   mul_res;

    logic [ALU_W:0]     add_full, sub_full;
    logic [ALU_W-1:0]   alu_res;
    logic               alu_ovf;

    assign op       = op_e'(i_op);
    assign o_ready  = (state_q == IDLE);
    assign accept   = i_valid && o_ready;
    assign mul_last = (state_q == MUL) && (cnt == LAST);

    // Final iteration folds in the last partial product so the result registers on the same edge.
    assign prod_next = acc + (mplier[0] ? mcand : '0);
    assign mul_ovf   = |prod_next[2*ALU_W-1:ALU_W];
    assign mul_res   = (SAT != 0 && mul_ovf) ? '1 : prod_next[ALU_W-1:0];

    // NOTE: every always_comb output gets a default first, otherwise an unassigned path infers a latch.
    always_comb begin
        add_full = {1'b0, i_data_a} + {1'b0, i_data_b};
        sub_full = {1'b0, i_data_a} - {1'b0, i_data_b};
        alu_res  = '0;
        alu_ovf  = 1'b0;
        case (op)
            OP_PUSH: begin
                alu_res = {i_data_a[ALU_W-IM_W-1:0], i_const};
                alu_ovf = |i_data_a[ALU_W-1 -: IM_W];
            end
            OP_ADD: begin
                alu_ovf = add_full[ALU_W];
                alu_res = (SAT != 0 && alu_ovf) ? '1 : add_full[ALU_W-1:0];
            end
            OP_SUB: begin
                alu_ovf = sub_full[ALU_W];
                alu_res = (SAT != 0 && alu_ovf) ? '0 : sub_full[ALU_W-1:0];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && op == OP_MULT) state_d = MUL;
            MUL:     if (cnt == LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            o_data  <= '0;
            o_valid <= 1'b0;
            o_ovf   <= 1'b0;
        end else begin
            state_q <= state_d;
            o_valid <= 1'b0;
            if (accept && op != OP_MULT) begin
                o_data  <= alu_res;
                o_ovf   <= alu_ovf;
                o_valid <= 1'b1;
            end else if (mul_last) begin
                o_data  <= mul_res;
                o_ovf   <= mul_ovf;
                o_valid <= 1'b1;
            end
        end
    end

    // NOTE: multiplier datapath has no reset; it is always loaded on accept before being read.
    always_ff @(posedge clk) begin
        if (accept && op == OP_MULT) begin
            acc    <= '0;
            mcand  <= {{ALU_W{1'b0}}, i_data_a};
            mplier <= i_data_b;
            cnt    <= '0;
        end else if (state_q == MUL) begin
            acc    <= prod_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_seq_alu_mc.sv
// Directed bench for seq_alu_mc: a wrap-around and a saturating instance share one stimulus stream.
module tb_seq_alu_mc;

    localparam int ALU_W = 8;
    localparam int IM_W  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [ALU_W-1:0] i_data_a, i_data_b;
    logic [1:0]       i_op;
    logic [IM_W-1:0]  i_const;
    logic             i_valid;

    logic             ready_w, valid_w, ovf_w;
    logic [ALU_W-1:0] data_w;
    logic             ready_s, valid_s, ovf_s;
    logic [ALU_W-1:0] data_s;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_alu_mc #(.ALU_W(ALU_W), .IM_W(IM_W), .SAT(0)) dut_wrap (
        .clk(clk), .rst(rst), .i_data_a(i_data_a), .i_data_b(i_data_b), .i_op(i_op),
        .i_const(i_const), .i_valid(i_valid), .o_ready(ready_w), .o_data(data_w),
        .o_valid(valid_w), .o_ovf(ovf_w)
    );

    seq_alu_mc #(.ALU_W(ALU_W), .IM_W(IM_W), .SAT(1)) dut_sat (
        .clk(clk), .rst(rst), .i_data_a(i_data_a), .i_data_b(i_data_b), .i_op(i_op),
        .i_const(i_const), .i_valid(i_valid), .o_ready(ready_s), .o_data(data_s),
        .o_valid(valid_s), .o_ovf(ovf_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] c);
        i_op     = op;
        i_data_a = a;
        i_data_b = b;
        i_const  = c;
        i_valid  = 1'b1;
    endtask

    task automatic check_res(input string tag, input logic [7:0] dw, input logic ow,
                             input logic [7:0] ds, input logic os);
        check({tag, ".valid_w"}, valid_w, 1'b1);
        check({tag, ".data_w"},  data_w,  dw);
        check({tag, ".ovf_w"},   ovf_w,   ow);
        check({tag, ".valid_s"}, valid_s, 1'b1);
        check({tag, ".data_s"},  data_s,  ds);
        check({tag, ".ovf_s"},   ovf_s,   os);
    endtask

    // Mult accepted at cycle 0: busy for cycles 1..8, result strobe at cycle 9.
    task automatic run_mult(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input bit hold_add, input logic [7:0] dw, input logic ow,
                            input logic [7:0] ds);
        int pulses;
        pulses = 0;
        apply(2'b10, a, b, 4'h0);
        tick();
        if (hold_add) apply(2'b01, 8'h01, 8'h01, 4'h0);
        else          i_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            check($sformatf("%s.busy_c%0d", tag, k), {ready_w, ready_s}, 2'b00);
            pulses += int'(valid_w);
            tick();
        end
        i_valid = 1'b0;
        check({tag, ".ready_c9"}, {ready_w, ready_s}, 2'b11);
        check_res({tag, ".c9"}, dw, ow, ds, ow);
        pulses += int'(valid_w);
        tick();
        pulses += int'(valid_w);
        check({tag, ".pulses"}, pulses, 1);
    endtask

    initial begin
        rst = 1'b0;
        apply(2'b01, 8'h03, 8'h04, 4'h0);
        tick();
        tick();
        check("rst.valid", {valid_w, valid_s}, 2'b00);
        check("rst.data",  {data_w, data_s}, 16'h0000);
        check("rst.ovf",   {ovf_w, ovf_s}, 2'b00);
        check("rst.ready", {ready_w, ready_s}, 2'b11);
        i_valid = 1'b0;
        rst = 1'b1;
        tick();
        check("rst.release_valid", {valid_w, valid_s}, 2'b00);

        // push 0x12,0x5: top nibble 0x1 is shifted out
        apply(2'b00, 8'h12, 8'h00, 4'h5);
        tick();
        i_valid = 1'b0;
        check_res("push", 8'h25, 1'b1, 8'h25, 1'b1);
        tick();
        check("push.strobe_low", {valid_w, valid_s}, 2'b00);
        check("push.hold", data_w, 8'h25);

        // push without overflow
        apply(2'b00, 8'h0A, 8'h00, 4'hC);
        tick();
        i_valid = 1'b0;
        check_res("push2", 8'hAC, 1'b0, 8'hAC, 1'b0);

        // back-to-back adds
        apply(2'b01, 8'hF0, 8'h20, 4'h0);
        tick();
        check_res("add_ovf", 8'h10, 1'b1, 8'hFF, 1'b1);
        apply(2'b01, 8'h01, 8'h02, 4'h0);
        tick();
        i_valid = 1'b0;
        check_res("add_b2b", 8'h03, 1'b0, 8'h03, 1'b0);

        apply(2'b11, 8'h05, 8'h07, 4'h0);
        tick();
        check_res("sub_borrow", 8'hFE, 1'b1, 8'h00, 1'b1);
        apply(2'b11, 8'h07, 8'h05, 4'h0);
        tick();
        i_valid = 1'b0;
        check_res("sub_ok", 8'h02, 1'b0, 8'h02, 1'b0);
        tick();

        run_mult("mul13x11", 8'd13, 8'd11, 1'b0, 8'h8F, 1'b0, 8'h8F);
        run_mult("mul_ovf", 8'h20, 8'h10, 1'b0, 8'h00, 1'b1, 8'hFF);
        run_mult("mul_hold", 8'd7, 8'd9, 1'b1, 8'h3F, 1'b0, 8'h3F);

        // new request accepted in the same cycle the mult result is strobed
        apply(2'b10, 8'd5, 8'd6, 4'h0);
        tick();
        i_valid = 1'b0;
        for (int k = 1; k <= 8; k++) tick();
        check("mul_then.valid", valid_w, 1'b1);
        check("mul_then.data", data_w, 8'd30);
        apply(2'b01, 8'h10, 8'h22, 4'h0);
        tick();
        i_valid = 1'b0;
        check_res("mul_then.add", 8'h32, 1'b0, 8'h32, 1'b0);

        // reset asserted at cycle 4 of a mult aborts it
        apply(2'b10, 8'd13, 8'd11, 4'h0);
        tick();
        i_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("abort.data", {data_w, data_s}, 16'h0000);
        check("abort.ready", {ready_w, ready_s}, 2'b11);
        begin
            int pulses;
            pulses = 0;
            for (int k = 0; k < 10; k++) begin
                pulses += int'(valid_w) + int'(valid_s);
                tick();
            end
            check("abort.no_valid", pulses, 0);
        end
        apply(2'b01, 8'h03, 8'h04, 4'h0);
        tick();
        i_valid = 1'b0;
        check_res("abort.add", 8'h07, 1'b0, 8'h07, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_alu_mc.md
SEQ_ALU_MC -- requirements
Module: seq_alu_mc

Interface
REQ-001 SHALL have parameter ALU_W, default 8: operand/result width, 4..32.
REQ-002 SHALL have parameter IM_W, default 4: push-constant width, 1..ALU_W-1.
REQ-003 SHALL have parameter SAT, default 0: 0 = wrap-around arithmetic, 1 = saturating add/sub/mult.
REQ-004 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-low reset.
REQ-006 SHALL have port i_data_a, input, ALU_W: operand A, unsigned.
REQ-007 SHALL have port i_data_b, input, ALU_W: operand B, unsigned.
REQ-008 SHALL have port i_op, input, 2: opcode, 00 push, 01 add, 10 mult, 11 sub.
REQ-009 SHALL have port i_const, input, IM_W: push immediate.
REQ-010 SHALL have port i_valid, input, 1: request strobe.
REQ-011 SHALL have port o_ready, output, 1: block can accept a request this cycle.
REQ-012 SHALL have port o_data, output, ALU_W: registered result.
REQ-013 SHALL have port o_valid, output, 1: one-cycle result strobe, no back-pressure.
REQ-014 SHALL have port o_ovf, output, 1: overflow flag qualified by o_valid.

Function
REQ-015 SHALL accept a request in any cycle with i_valid=1 and o_ready=1, capturing i_data_a, i_data_b, i_op and i_const.
REQ-016 SHALL implement FSM states IDLE and MUL: IDLE->MUL on an accepted mult; MUL->IDLE after ALU_W iteration cycles; all other ops stay in IDLE.
REQ-017 SHALL drive o_ready=1 in IDLE and o_ready=0 in MUL.
REQ-018 SHALL ignore i_valid while o_ready=0: no capture, no state change, no error.
REQ-019 SHALL, for push, add and sub accepted in cycle N, assert o_valid in cycle N+1 with the result, allowing back-to-back accepts every cycle.
REQ-020 SHALL compute mult with a radix-2 shift-add engine over ALU_W cycles, asserting o_valid in cycle N+ALU_W+1 for an accept in cycle N.
REQ-021 SHALL compute push as the low ALU_W bits of (A << IM_W) | const; o_ovf=1 when any bit shifted out is nonzero; push never saturates.
REQ-022 SHALL compute add as A+B modulo 2^ALU_W; o_ovf = carry out.
REQ-023 SHALL compute sub as A-B modulo 2^ALU_W; o_ovf = borrow (A<B).
REQ-024 SHALL compute mult from a 2*ALU_W-bit product and return its low ALU_W bits; o_ovf=1 when the upper ALU_W bits are nonzero.
REQ-025 SHALL, with SAT=1 and o_ovf=1, replace the result with all-ones for add and mult and all-zeros for sub.
REQ-026 SHALL hold o_data and o_ovf between results; o_valid is high for exactly one cycle per accepted request.
REQ-027 SHALL accept a new request in the cycle o_valid is high for a mult, because the FSM has already returned to IDLE.

Reset
REQ-028 SHALL, while rst=0 at a clock edge, set state=IDLE, o_data=0, o_valid=0, o_ovf=0 and o_ready=1 from the next cycle.
REQ-029 SHALL make reset mid-mult abort the operation with no o_valid pulse; i_valid coincident with rst=0 is not accepted.

Verification (ALU_W=8, IM_W=4)
REQ-030 SHALL cover push A=0x12, const=0x5 -> o_data=0x25, o_ovf=1, o_valid one cycle after accept.
REQ-031 SHALL cover add 0xF0+0x20 -> 0x10 with o_ovf=1 when SAT=0; 0xFF with o_ovf=1 when SAT=1; then back-to-back add 0x01+0x02 -> 0x03 with o_ovf=0 on the next cycle.
REQ-032 SHALL cover sub 0x05-0x07 -> 0xFE with o_ovf=1 when SAT=0; 0x00 when SAT=1.
REQ-033 SHALL cover mult 13*11 accepted at cycle 0 -> o_ready=0 for cycles 1..8, o_valid at cycle 9, o_data=0x8F, o_ovf=0; 0x20*0x10 -> 0x00 with o_ovf=1 (0xFF when SAT=1).
REQ-034 SHALL cover i_valid held high with add 0x01+0x01 during a mult -> ignored, exactly one o_valid carrying the mult result.
REQ-035 SHALL cover rst=0 at cycle 4 of a mult -> no o_valid, o_data=0, o_ready=1 after reset release, and a following add 0x03+0x04 -> 0x07.
